// File: rtl/apb_master_bridge.sv
// ---------------------------------------------------------------------------
// apb_master_bridge
//
// Single-outstanding APB3 requester. A valid/ready command channel from the
// system side is turned into exactly one APB SETUP/ACCESS transfer. The read
// data and error status come back on a valid/ready response channel.
//
// Optional feature macro: APB_MASTER_TIMEOUT_EN
//   When defined, a watchdog aborts an ACCESS phase that has stalled for
//   TIMEOUT_CYCLES wait edges. The aborted transfer reports rsp_err = 1 and
//   rsp_timeout = 1. When undefined, ACCESS waits indefinitely and
//   rsp_timeout is tied low.
//
// Ports:
//   PCLK, PRESET         clock (rising edge), asynchronous active-high reset
//   cmd_valid/cmd_ready  command handshake (accepted when both high)
//   cmd_write            1 = write, 0 = read
//   cmd_addr, cmd_wdata  command address / write data
//   rsp_valid/rsp_ready  response handshake (consumed when both high)
//   rsp_rdata            read data (0 for writes and timeouts)
//   rsp_err              PSLVERR captured, or watchdog abort
//   rsp_timeout          transfer aborted by watchdog
//   PSEL, PENABLE        APB controls (registered)
//   PWRITE, PADDR        APB direction / address (registered)
//   PWDATA               APB write data (registered)
//   PRDATA, PREADY       APB slave returns
//   PSLVERR              APB slave error
// ---------------------------------------------------------------------------
module apb_master_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // A watchdog limit of zero would abort before any wait edge could occur.
    if (TIMEOUT_CYCLES < 1) begin : g_badTimeoutCfg
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t                r_state;
    state_t                w_nextState;
    logic                  w_accept;
    logic                  w_timeout;

    logic                  r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic                  r_rspValid;
    logic [DATA_WIDTH-1:0] r_rspRdata;
    logic                  r_rspErr;

    // Only IDLE takes commands, so at most one transfer is ever in flight.
    // Ready is also masked by reset so nothing is handshaken while the
    // state register is being held.
    assign cmd_ready = (r_state == IDLE) && !PRESET;
    assign w_accept  = (r_state == IDLE) && cmd_valid;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CountWidth = $clog2(TIMEOUT_CYCLES + 1);

    logic [CountWidth-1:0] r_waitCount;
    logic                  r_rspTimeout;

    // The abort fires on the stalled edge that would be the
    // TIMEOUT_CYCLES-th wait; PREADY arriving on that same edge still
    // completes the transfer normally.
    assign w_timeout = (r_state == ACCESS) && !PREADY &&
                       (r_waitCount == CountWidth'(TIMEOUT_CYCLES - 1));

    // Wait counter restarts in SETUP so every ACCESS phase begins from zero.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_waitCount  <= '0;
            r_rspTimeout <= 1'b0;
        end else begin
            if (r_state == SETUP) begin
                r_waitCount <= '0;
            end else if ((r_state == ACCESS) && !PREADY) begin
                r_waitCount <= r_waitCount + CountWidth'(1);
            end
            if ((r_state == ACCESS) && (PREADY || w_timeout)) begin
                r_rspTimeout <= !PREADY;
            end
        end
    end

    assign rsp_timeout = r_rspTimeout;
`else
    assign w_timeout   = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. PREADY is only looked at in ACCESS, so a ready
    // seen during SETUP has no effect.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (cmd_valid) w_nextState = SETUP;
            SETUP:   w_nextState = ACCESS;
            ACCESS:  if (PREADY || w_timeout) w_nextState = RESP;
            RESP:    if (rsp_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // APB and response outputs are registered from the next state so they
    // line up with the state they belong to. Address, direction and write
    // data are loaded only on acceptance and otherwise hold their values.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_psel     <= 1'b0;
            r_penable  <= 1'b0;
            r_pwrite   <= 1'b0;
            r_paddr    <= '0;
            r_pwdata   <= '0;
            r_rspValid <= 1'b0;
            r_rspRdata <= '0;
            r_rspErr   <= 1'b0;
        end else begin
            r_psel     <= (w_nextState == SETUP) || (w_nextState == ACCESS);
            r_penable  <= (w_nextState == ACCESS);
            r_rspValid <= (w_nextState == RESP);
            if (w_accept) begin
                r_pwrite <= cmd_write;
                r_paddr  <= cmd_addr;
                r_pwdata <= cmd_wdata;
            end
            if (r_state == ACCESS) begin
                if (PREADY) begin
                    r_rspErr   <= PSLVERR;
                    r_rspRdata <= r_pwrite ? '0 : PRDATA;
                end else if (w_timeout) begin
                    r_rspErr   <= 1'b1;
                    r_rspRdata <= '0;
                end
            end
        end
    end

    assign PSEL       = r_psel;
    assign PENABLE    = r_penable;
    assign PWRITE     = r_pwrite;
    assign PADDR      = r_paddr;
    assign PWDATA     = r_pwdata;
    assign rsp_valid  = r_rspValid;
    assign rsp_rdata  = r_rspRdata;
    assign rsp_err    = r_rspErr;

endmodule

// File: tb/tb_apb_master_bridge.sv
// ---------------------------------------------------------------------------
// tb_apb_master_bridge
//
// Self-checking bench for apb_master_bridge. A transaction-level model
// (in-flight command, its age in cycles since acceptance, and a pending
// response) predicts every output and is compared on each falling edge.
// Directed scenarios pin the model with literal expectations, followed by
// a randomized phase with occasional asynchronous reset pulses.
// Build with APB_MASTER_TIMEOUT_EN defined to exercise the watchdog.
// ---------------------------------------------------------------------------
module tb_apb_master_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          PCLK = 1'b0;
    logic          PRESET = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA = '0;
    logic          PREADY = 1'b0;
    logic          PSLVERR = 1'b0;

    always #5 PCLK = ~PCLK;

    apb_master_bridge #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    int totalChecks = 0;
    int badChecks   = 0;
    bit checkEn     = 1'b1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        totalChecks++;
        if (actual !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Present a command for exactly one edge; the caller makes sure the
    // bridge is idle so that edge is the acceptance edge. Returns just
    // after that edge (start of cycle 1).
    task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                                 input logic [31:0] data);
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = data;
        cmd_valid = 1'b1;
        @(posedge PCLK);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Transaction model: mAge counts cycles since the command was taken
    // (0 = nothing in flight, 1 = address phase, >=2 = enable phase).
    int            mAge     = 0;
    int            mWaits   = 0;
    bit            mRspPend = 1'b0;
    bit            mAcc     = 1'b0;
    logic          mWrite   = 1'b0;
    logic [AW-1:0] mAddr    = '0;
    logic [DW-1:0] mWdata   = '0;
    logic [DW-1:0] mRdata   = '0;
    logic          mErr     = 1'b0;
    logic          mTo      = 1'b0;

    always @(posedge PCLK or posedge PRESET) begin
        mAcc = 1'b0;
        if (PRESET) begin
            mAge = 0; mWaits = 0; mRspPend = 1'b0;
            mWrite = 1'b0; mAddr = '0; mWdata = '0;
            mRdata = '0; mErr = 1'b0; mTo = 1'b0;
        end else if (mRspPend) begin
            if (rsp_ready) mRspPend = 1'b0;
        end else if (mAge == 0) begin
            if (cmd_valid) begin
                mWrite = cmd_write; mAddr = cmd_addr; mWdata = cmd_wdata;
                mAge = 1; mAcc = 1'b1;
            end
        end else if (mAge == 1) begin
            mAge = 2; mWaits = 0;
        end else begin
            mAge++;
            if (PREADY) begin
                mRdata = mWrite ? '0 : PRDATA;
                mErr = PSLVERR; mTo = 1'b0;
                mRspPend = 1'b1; mAge = 0;
            end else begin
                mWaits++;
`ifdef APB_MASTER_TIMEOUT_EN
                if (mWaits == TO) begin
                    mRdata = '0; mErr = 1'b1; mTo = 1'b1;
                    mRspPend = 1'b1; mAge = 0;
                end
`endif
            end
        end
    end

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge PCLK) begin
        if (checkEn) begin
            checkOutput("cmd_ready",   cmd_ready,   32'(!PRESET && mAge == 0 && !mRspPend));
            checkOutput("PSEL",        PSEL,        32'(mAge >= 1));
            checkOutput("PENABLE",     PENABLE,     32'(mAge >= 2));
            checkOutput("PWRITE",      PWRITE,      32'(mWrite));
            checkOutput("PADDR",       PADDR,       mAddr);
            checkOutput("PWDATA",      PWDATA,      mWdata);
            checkOutput("rsp_valid",   rsp_valid,   32'(mRspPend));
            checkOutput("rsp_rdata",   rsp_rdata,   mRdata);
            checkOutput("rsp_err",     rsp_err,     32'(mErr));
            checkOutput("rsp_timeout", rsp_timeout, 32'(mTo));
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running, required finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset values
        repeat (2) @(negedge PCLK);
        checkOutput("rst_cmd_ready", cmd_ready, 0);
        checkOutput("rst_psel",      PSEL,      0);
        checkOutput("rst_paddr",     PADDR,     0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        @(posedge PCLK);
        #1 PRESET = 1'b0;
        @(negedge PCLK);
        checkOutput("release_cmd_ready", cmd_ready, 1);
        checkOutput("release_psel",      PSEL,      0);

        // Zero-wait write
        PREADY = 1'b1; rsp_ready = 1'b1;
        applyStimulus(1'b1, 32'h10, 32'hDEADBEEF);
        @(negedge PCLK);
        checkOutput("wr_c1_psel",    PSEL,    1);
        checkOutput("wr_c1_penable", PENABLE, 0);
        checkOutput("wr_c1_paddr",   PADDR,   32'h10);
        checkOutput("wr_c1_pwdata",  PWDATA,  32'hDEADBEEF);
        @(negedge PCLK);
        checkOutput("wr_c2_penable", PENABLE, 1);
        @(negedge PCLK);
        checkOutput("wr_c3_rsp_valid", rsp_valid, 1);
        checkOutput("wr_c3_rsp_err",   rsp_err,   0);
        checkOutput("wr_c3_rsp_rdata", rsp_rdata, 0);
        @(negedge PCLK);
        checkOutput("wr_c4_cmd_ready", cmd_ready, 1);

        // Read with three wait states
        PREADY = 1'b0; PRDATA = '0;
        applyStimulus(1'b0, 32'h20, 32'h0);
        for (int c = 1; c <= 6; c++) begin
            @(negedge PCLK);
            if (c >= 2 && c <= 5) checkOutput($sformatf("rd_c%0d_penable", c), PENABLE, 1);
            if (c <= 5) checkOutput($sformatf("rd_c%0d_paddr", c), PADDR, 32'h20);
            if (c == 5) begin
                checkOutput("rd_c5_rsp_valid", rsp_valid, 0);
                PREADY = 1'b1; PRDATA = 32'hCAFEF00D;
            end
            if (c == 6) begin
                checkOutput("rd_c6_rsp_valid", rsp_valid, 1);
                checkOutput("rd_c6_rsp_rdata", rsp_rdata, 32'hCAFEF00D);
            end
        end
        @(negedge PCLK);

        // Slave error: data still captured
        PSLVERR = 1'b1; PRDATA = 32'h1;
        applyStimulus(1'b0, 32'h30, 32'h0);
        repeat (3) @(negedge PCLK);
        checkOutput("err_rsp_err",     rsp_err,     1);
        checkOutput("err_rsp_rdata",   rsp_rdata,   32'h1);
        checkOutput("err_rsp_timeout", rsp_timeout, 0);
        @(negedge PCLK);
        PSLVERR = 1'b0;

        // Response backpressure with the next command held upstream
        rsp_ready = 1'b0; PRDATA = 32'h12345678;
        applyStimulus(1'b0, 32'h40, 32'h0);
        cmd_write = 1'b1; cmd_addr = 32'h44; cmd_wdata = 32'h0000A5A5;
        cmd_valid = 1'b1;
        repeat (2) @(negedge PCLK);
        for (int c = 3; c <= 7; c++) begin
            @(negedge PCLK);
            checkOutput($sformatf("bp_c%0d_rsp_valid", c), rsp_valid, 1);
            checkOutput($sformatf("bp_c%0d_rsp_rdata", c), rsp_rdata, 32'h12345678);
            checkOutput($sformatf("bp_c%0d_cmd_ready", c), cmd_ready, 0);
            PRDATA = $urandom;
        end
        rsp_ready = 1'b1;
        @(negedge PCLK);
        checkOutput("bp_c8_cmd_ready", cmd_ready, 1);
        checkOutput("bp_c8_rsp_valid", rsp_valid, 0);
        @(posedge PCLK);
        #1 cmd_valid = 1'b0;
        @(negedge PCLK);
        checkOutput("bp_c9_psel",  PSEL,  1);
        checkOutput("bp_c9_paddr", PADDR, 32'h44);
        repeat (4) @(negedge PCLK);

        // Reset in the middle of ACCESS
        PREADY = 1'b0;
        applyStimulus(1'b1, 32'h50, 32'h77);
        repeat (2) @(negedge PCLK);
        checkOutput("mid_c2_penable", PENABLE, 1);
        #1 PRESET = 1'b1;
        #1;
        checkOutput("mid_rst_psel",    PSEL,    0);
        checkOutput("mid_rst_penable", PENABLE, 0);
        checkOutput("mid_rst_paddr",   PADDR,   0);
        @(posedge PCLK);
        #1 PRESET = 1'b0; PREADY = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge PCLK);
            checkOutput("mid_no_rsp", rsp_valid, 0);
        end

`ifdef APB_MASTER_TIMEOUT_EN
        // Watchdog abort after TO stalled edges
        PREADY = 1'b0;
        applyStimulus(1'b0, 32'h60, 32'h0);
        for (int c = 1; c <= TO + 2; c++) begin
            @(negedge PCLK);
            if (c >= 2 && c <= TO + 1) checkOutput("to_penable", PENABLE, 1);
            if (c == TO + 2) begin
                checkOutput("to_rsp_valid",   rsp_valid,   1);
                checkOutput("to_rsp_err",     rsp_err,     1);
                checkOutput("to_rsp_timeout", rsp_timeout, 1);
                checkOutput("to_rsp_rdata",   rsp_rdata,   0);
                checkOutput("to_psel",        PSEL,        0);
            end
        end
        PREADY = 1'b1;
        @(negedge PCLK);
`endif

        // Randomized traffic with occasional reset pulses
        for (int n = 0; n < 3000; n++) begin
            @(posedge PCLK);
            #1;
            if (PRESET) PRESET = 1'b0;
            else if ($urandom_range(0, 399) == 0) PRESET = 1'b1;
            if (!(cmd_valid && !mAcc)) begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_write = 1'($urandom_range(0, 1));
                cmd_addr  = $urandom;
                cmd_wdata = $urandom;
            end
            PREADY    = ($urandom_range(0, 9) < 6);
            PSLVERR   = ($urandom_range(0, 3) == 0);
            PRDATA    = $urandom;
            rsp_ready = ($urandom_range(0, 9) < 6);
        end
        @(negedge PCLK);
        PRESET = 1'b0;
        @(negedge PCLK);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

Single-outstanding APB3 requester that drives the `apb_slave` port set. A simple valid/ready command channel comes in from the system side. The block issues exactly one APB SETUP/ACCESS transfer per command and returns read data and error status on a valid/ready response channel. It is the stage directly upstream of `apb_slave` and replaces hand-driven PSEL/PENABLE stimulus in system-level benches.

## Interface
- `ADDR_WIDTH`, 32, PADDR / cmd_addr width
- `DATA_WIDTH`, 32, PWDATA / PRDATA / data width
- `TIMEOUT_CYCLES`, 256, ACCESS wait-state limit (used only with the timeout feature)

Ports:
- `PCLK`  in  1  clock, all state on rising edge
- `PRESET`  in  1  asynchronous, active-high reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  command accepted when both high at an edge
- `cmd_write`  in  1  1 = write, 0 = read
- `cmd_addr`  in  ADDR_WIDTH  transfer address
- `cmd_wdata`  in  DATA_WIDTH  write data (ignored for reads)
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  response consumed when both high at an edge
- `rsp_rdata`  out  DATA_WIDTH  read data; 0 for writes and timeouts
- `rsp_err`  out  1  PSLVERR captured, or timeout
- `rsp_timeout`  out  1  transfer aborted by watchdog
- `PSEL`, `PENABLE`, `PWRITE`  out  1  APB controls
- `PADDR`  out  ADDR_WIDTH, `PWDATA`  out  DATA_WIDTH  APB address/data
- `PRDATA`  in  DATA_WIDTH, `PREADY`  in  1, `PSLVERR`  in  1  APB returns

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. Reset state is IDLE.
- IDLE
  - `cmd_ready` = 1.
  - On `cmd_valid`, register write/addr/wdata onto `PWRITE`/`PADDR`/`PWDATA` and go to SETUP.
- SETUP
  - `PSEL` = 1, `PENABLE` = 0.
  - Unconditionally go to ACCESS.
- ACCESS
  - `PSEL` = 1, `PENABLE` = 1.
  - `PREADY` = 0: stay in ACCESS.
  - `PREADY` = 1: capture `PSLVERR` into `rsp_err`. Capture `PRDATA` into `rsp_rdata` on reads; load 0 on writes. Go to RESP.
  - `PRDATA` is captured even when `PSLVERR` = 1.
- RESP
  - `rsp_valid` = 1 and held, with data stable, until `rsp_ready`.
  - Then go to IDLE.
- `cmd_ready` is 0 in all states other than IDLE; only one transfer is ever outstanding.
- `PADDR`, `PWRITE` and `PWDATA` are constant from SETUP through the final ACCESS cycle. They retain their last values in IDLE/RESP.
- All APB and response outputs are registered. `cmd_ready` = (state == IDLE) && !PRESET.
- Reset values (asserted asynchronously): all outputs 0, including `PADDR`, `PWDATA`, `rsp_rdata` and `cmd_ready`.
- Reset mid-transfer: `PSEL`/`PENABLE` drop immediately. Any in-flight command and pending response are discarded. No response is produced.

## Timing
- Zero-wait transfer, cmd handshake at edge 0:
  - SETUP during cycle 1.
  - ACCESS during cycle 2.
  - `rsp_valid` high from cycle 3.
- Each ACCESS cycle with `PREADY` = 0 adds one cycle.
- With `rsp_ready` held high:
  - RESP lasts 1 cycle.
  - `cmd_ready` returns in cycle 4.
  - Minimum is 4 cycles per transfer.
- `cmd_valid` asserted during RESP is not accepted until IDLE. Upstream holds it, unchanged, until `cmd_ready`.
- `PREADY` sampled in SETUP is ignored.

## Configuration
- Macro: `APB_MASTER_TIMEOUT_EN`.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entering ACCESS.
  - It increments on each ACCESS edge with `PREADY` = 0.
  - When the count reaches `TIMEOUT_CYCLES` with `PREADY` still 0, the transfer aborts and goes to RESP with `rsp_err` = 1, `rsp_timeout` = 1, `rsp_rdata` = 0.
  - `PSEL`/`PENABLE` go to 0 in the RESP cycle.
  - `PREADY` = 1 on the same edge as the limit wins: normal completion, `rsp_timeout` = 0.
- Undefined:
  - No counter.
  - ACCESS waits indefinitely.
  - `rsp_timeout` is tied 0.

## Test plan
- Reset check: assert `PRESET` → all outputs 0. Deassert → `cmd_ready` = 1 next cycle, `PSEL` = 0.
- Zero-wait write:
  - Stimulus: cmd write addr 0x10, data 0xDEADBEEF.
  - Cycle 1: `PSEL` = 1, `PENABLE` = 0, `PADDR` = 0x10.
  - Cycle 2: `PENABLE` = 1.
  - Cycle 3: `rsp_valid` = 1, `rsp_err` = 0, `rsp_rdata` = 0.
- Read with 3 wait states:
  - Stimulus: slave holds `PREADY` low 3 cycles, then returns `PRDATA` = 0xCAFEF00D.
  - Required: ACCESS lasts 4 cycles; `rsp_rdata` = 0xCAFEF00D; `PADDR` stable throughout.
- Slave error: read with `PSLVERR` = 1 and `PRDATA` = 0x1 on the `PREADY` cycle → `rsp_err` = 1, `rsp_rdata` = 0x1, `rsp_timeout` = 0.
- Response backpressure: hold `rsp_ready` = 0 for 5 cycles with `cmd_valid` = 1 → `rsp_valid`/data held stable, `cmd_ready` = 0. The next command is accepted only after the response handshake.
- Timeout (`APB_MASTER_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 8):
  - `PREADY` held 0 → abort after 8 wait edges, with `rsp_err` = 1, `rsp_timeout` = 1, `PSEL` = 0.
  - Separately, assert `PRESET` mid-ACCESS → `PSEL`/`PENABLE` drop at once, no response.
